des_iter_core: RTL
==================

DES_ITER_CORE -- requirements
Module: des_iter_core

Interface
REQ-001 SHALL have parameter UNROLL, default 1, giving Feistel rounds per clock; legal values 1, 2, 4, 8, 16; any other value fails elaboration.
REQ-002 SHALL have port clk, input, 1, the single clock.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port in_valid, input, 1, a request is present.
REQ-005 SHALL have port in_ready, output, 1, the core accepts a request.
REQ-006 SHALL have port decrypt, input, 1: 0 = encrypt, 1 = decrypt; sampled at accept.
REQ-007 SHALL have port key_in, input, 64, DES key with parity bits ignored; bit 1 is the MSB.
REQ-008 SHALL have port data_in, input, 64, plaintext or ciphertext; bit 1 is the MSB.
REQ-009 SHALL have port out_valid, output, 1, the result is present.
REQ-010 SHALL have port out_ready, input, 1, the consumer accepts the result.
REQ-011 SHALL have port data_out, output, 64, the result after FP (inverse IP).
REQ-012 SHALL have port busy, output, 1, high in RUN or DONE.

Function
REQ-013 SHALL implement FSM states IDLE, RUN and DONE.
REQ-014 SHALL drive in_ready = (state == IDLE); a request is accepted on a clk edge with in_valid & in_ready.
REQ-015 On accept, SHALL register IP(data_in) into L/R, PC1(key_in) into C/D, and decrypt into the mode register; round counter = 0; go to RUN.
REQ-016 In RUN, SHALL apply UNROLL rounds per cycle combinationally and advance the counter by UNROLL.
REQ-017 Encrypt: round i (1..16) SHALL left-rotate C/D by the standard schedule (1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1) before PC2.
REQ-018 Decrypt: SHALL use subkeys K16..K1 by right-rotating C/D with schedule (0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1), with the rotation applied before PC2.
REQ-019 Each round: L' = R, R' = L ^ f(R, K); after round 16 the halves SHALL be swapped, data_out = FP({R16, L16}) registered.
REQ-020 Latency: accept at edge N SHALL give out_valid high after edge N + 16/UNROLL (UNROLL=1: 16 cycles; UNROLL=16: 1 cycle).
REQ-021 In DONE, SHALL hold out_valid = 1 and data_out stable until out_valid & out_ready, then return to IDLE next cycle.
REQ-022 in_valid asserted while not IDLE SHALL be ignored, with no state change.
REQ-023 Changes on key_in, data_in or decrypt after accept SHALL not affect the running operation.
REQ-024 The counter SHALL be $clog2(17) bits wide, reach exactly 16, and never wrap.
REQ-025 out_valid SHALL never be high in IDLE or RUN.

Reset
REQ-026 rst_n low SHALL, asynchronously, force IDLE, counter 0, L/R/C/D/data_out 0, out_valid 0, in_ready 1 (after reset), busy 0.
REQ-027 Reset mid-RUN or mid-DONE SHALL abort the operation with no result emitted; the first accept after release SHALL behave normally.

Structure
REQ-028 Package des_pkg SHALL hold the IP, FP, E, P, PC1 and PC2 tables, the 8 S-boxes, both shift schedules, and the state enum.
REQ-029 Sub-module des_round SHALL perform one round plus key rotation (inputs L, R, C, D, round index, mode; outputs the next L, R, C, D) and is instantiated UNROLL times in a chain.
REQ-030 The existing f_function SHALL be reused inside des_round.

Verification
REQ-031 Encrypt with key 133457799BBCDFF1 and data 0123456789ABCDEF SHALL give data_out 85E813540F0AB405, for every legal UNROLL.
REQ-032 Decrypt with key 133457799BBCDFF1 and data 85E813540F0AB405 SHALL give 0123456789ABCDEF; encrypt with key 0 and data 0 SHALL give 8CA64DE9C1B123A7.
REQ-033 Latency: with UNROLL=4, accept at cycle 0 SHALL give out_valid at cycle 4; UNROLL=1 gives cycle 16; UNROLL=16 gives cycle 1.
REQ-034 Back-pressure: out_ready held low for 10 cycles SHALL keep data_out stable and in_ready 0, while in_valid pulses are ignored; out_ready=1 then gives IDLE on the next cycle.
REQ-035 Reset pulse at RUN round 8 SHALL give out_valid 0 and in_ready 1; a fresh REQ-031 request then SHALL still produce 85E813540F0AB405.
REQ-036 Inputs randomised between accept and result SHALL leave the result equal to the golden model across 1000 random key/data/mode triples.

Source files
------------

// File: rtl/des_pkg.sv
// DES constant tables, key schedules, FSM states and the
// bit-permutation helpers shared by the iterative core.
package des_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } des_state_e;

  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2,
    60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,
    64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1,
    59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,
    63, 55, 47, 39, 31, 23, 15, 7
  };

  localparam int FP_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32,
    39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30,
    37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28,
    35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26,
    33, 1, 41,  9, 49, 17, 57, 25
  };

  localparam int E_T [48] = '{
    32,  1,  2,  3,  4,  5,
     4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13,
    12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21,
    20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29,
    28, 29, 30, 31, 32,  1
  };

  localparam int P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,
     1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9,
    19, 13, 30,  6, 22, 11,  4, 25
  };

  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  localparam int SBOX [8][64] = '{
    '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,
       0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
       4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0,
      15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
    '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,
       3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
       0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15,
      13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
    '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8,
      13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
      13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,
       1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
    '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15,
      13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
      10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,
       3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
    '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9,
      14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
       4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14,
      11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
    '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11,
      10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
       9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,
       4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
    '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1,
      13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
       1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,
       6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
    '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,
       1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
       7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,
       2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}
  };

  localparam int SHIFT_ENC [16] = '{
    1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1
  };

  localparam int SHIFT_DEC [16] = '{
    0, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1
  };

  function automatic logic [63:0] perm_ip(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 64; i++)
      y[6'(63 - i)] = x[6'(64 - IP_T[6'(i)])];
    return y;
  endfunction

  function automatic logic [63:0] perm_fp(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 64; i++)
      y[6'(63 - i)] = x[6'(64 - FP_T[6'(i)])];
    return y;
  endfunction

  function automatic logic [47:0] perm_e(input logic [31:0] x);
    logic [47:0] y;
    y = '0;
    for (int i = 0; i < 48; i++)
      y[6'(47 - i)] = x[5'(32 - E_T[6'(i)])];
    return y;
  endfunction

  function automatic logic [31:0] perm_p(input logic [31:0] x);
    logic [31:0] y;
    y = '0;
    for (int i = 0; i < 32; i++)
      y[5'(31 - i)] = x[5'(32 - P_T[5'(i)])];
    return y;
  endfunction

  function automatic logic [55:0] perm_pc1(input logic [63:0] x);
    logic [55:0] y;
    y = '0;
    for (int i = 0; i < 56; i++)
      y[6'(55 - i)] = x[6'(64 - PC1_T[6'(i)])];
    return y;
  endfunction

  function automatic logic [47:0] perm_pc2(input logic [55:0] x);
    logic [47:0] y;
    y = '0;
    for (int i = 0; i < 48; i++)
      y[6'(47 - i)] = x[6'(56 - PC2_T[6'(i)])];
    return y;
  endfunction

  function automatic logic [3:0] sbox(
    input logic [2:0] s,
    input logic [5:0] b
  );
    return 4'(SBOX[s][{b[5], b[0], b[4:1]}]);
  endfunction

  function automatic logic [27:0] rot28(
    input logic [27:0] x,
    input logic [1:0]  n,
    input logic        right
  );
    logic [27:0] y;
    y = x;
    unique case (1'b1)
      (n == 2'd1 && !right): y = {x[26:0], x[27]};
      (n == 2'd2 && !right): y = {x[25:0], x[27:26]};
      (n == 2'd1 && right):  y = {x[0], x[27:1]};
      (n == 2'd2 && right):  y = {x[1:0], x[27:2]};
      default:               y = x;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/des_round.sv
// One Feistel round including the C/D rotation
// that produces this round's subkey.
module des_round
  import des_pkg::*;
(
  input  logic [31:0] i_l,
  input  logic [31:0] i_r,
  input  logic [27:0] i_c,
  input  logic [27:0] i_d,
  input  logic [3:0]  i_idx,
  input  logic        i_dec,
  output logic [31:0] o_l,
  output logic [31:0] o_r,
  output logic [27:0] o_c,
  output logic [27:0] o_d
);

  logic [1:0]  w_sh;
  logic [27:0] w_c;
  logic [27:0] w_d;
  logic [47:0] w_k;
  logic [31:0] w_f;

  // decrypt walks the schedule backwards by rotating right
  always_comb begin
    w_sh = i_dec ? 2'(SHIFT_DEC[i_idx])
                 : 2'(SHIFT_ENC[i_idx]);
    w_c  = rot28(i_c, w_sh, i_dec);
    w_d  = rot28(i_d, w_sh, i_dec);
    w_k  = perm_pc2({w_c, w_d});
  end

  f_function u_f (
    .i_r (i_r),
    .i_k (w_k),
    .o_f (w_f)
  );

  assign o_l = i_r;
  assign o_r = i_l ^ w_f;
  assign o_c = w_c;
  assign o_d = w_d;

endmodule

// File: rtl/f_function.sv
// DES f: expand R, mix in the subkey,
// squeeze through the S-boxes, then permute.
module f_function
  import des_pkg::*;
(
  input  logic [31:0] i_r,
  input  logic [47:0] i_k,
  output logic [31:0] o_f
);

  logic [47:0] w_x;
  logic [31:0] w_s;

  // expansion + key mix, then eight 6->4 substitutions
  always_comb begin
    w_x = perm_e(i_r) ^ i_k;
    w_s = '0;
    for (int s = 0; s < 8; s++)
      w_s[5'(31 - 4 * s) -: 4] =
        sbox(3'(s), w_x[6'(47 - 6 * s) -: 6]);
  end

  assign o_f = perm_p(w_s);

endmodule

// File: rtl/des_iter_core.sv
// Iterative DES engine: UNROLL rounds per clock,
// valid/ready on both request and result sides.
module des_iter_core
  import des_pkg::*;
#(
  parameter int UNROLL = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        decrypt,
  input  logic [63:0] key_in,
  input  logic [63:0] data_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] data_out,
  output logic        busy
);

  localparam int CW = $clog2(17);

  generate
    if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4 ||
          UNROLL == 8 || UNROLL == 16)) begin : g_bad
      $error("UNROLL must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  des_state_e    r_state;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_l;
  logic [31:0]   r_r;
  logic [27:0]   r_c;
  logic [27:0]   r_d;
  logic          r_dec;
  logic [63:0]   r_dout;
  logic          r_ov;
  logic          r_ir;
  logic          r_busy;

  logic [31:0] w_l   [UNROLL+1];
  logic [31:0] w_r   [UNROLL+1];
  logic [27:0] w_c   [UNROLL+1];
  logic [27:0] w_d   [UNROLL+1];
  logic [3:0]  w_idx [UNROLL];
  logic [63:0] w_ip;
  logic [55:0] w_pc1;
  logic [63:0] w_fp;
  logic        w_last;

  assign w_l[0] = r_l;
  assign w_r[0] = r_r;
  assign w_c[0] = r_c;
  assign w_d[0] = r_d;

  genvar j;
  generate
    for (j = 0; j < UNROLL; j++) begin : g_rnd
      assign w_idx[j] = r_cnt[3:0] + 4'(j);
      des_round u_round (
        .i_l   (w_l[j]),
        .i_r   (w_r[j]),
        .i_c   (w_c[j]),
        .i_d   (w_d[j]),
        .i_idx (w_idx[j]),
        .i_dec (r_dec),
        .o_l   (w_l[j+1]),
        .o_r   (w_r[j+1]),
        .o_c   (w_c[j+1]),
        .o_d   (w_d[j+1])
      );
    end
  endgenerate

  assign w_ip   = perm_ip(data_in);
  assign w_pc1  = perm_pc1(key_in);
  assign w_fp   = perm_fp({w_r[UNROLL], w_l[UNROLL]});
  assign w_last = (r_cnt == CW'(16 - UNROLL));

  // request/run/result sequencing with registered handshakes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_l     <= '0;
      r_r     <= '0;
      r_c     <= '0;
      r_d     <= '0;
      r_dec   <= 1'b0;
      r_dout  <= '0;
      r_ov    <= 1'b0;
      r_ir    <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_l     <= w_ip[63:32];
            r_r     <= w_ip[31:0];
            r_c     <= w_pc1[55:28];
            r_d     <= w_pc1[27:0];
            r_dec   <= decrypt;
            r_cnt   <= '0;
            r_ir    <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_l   <= w_l[UNROLL];
          r_r   <= w_r[UNROLL];
          r_c   <= w_c[UNROLL];
          r_d   <= w_d[UNROLL];
          r_cnt <= r_cnt + CW'(UNROLL);
          if (w_last) begin
            r_dout  <= w_fp;
            r_ov    <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_ov    <= 1'b0;
            r_ir    <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_ir    <= 1'b1;
          r_busy  <= 1'b0;
          r_ov    <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_ir;
  assign out_valid = r_ov;
  assign data_out  = r_dout;
  assign busy      = r_busy;

endmodule
